// File: rtl/wdt_multi_win.sv
// Multi-channel windowed watchdog: shared prescaler, per-channel reload,
// closed-window early-kick detection, warn threshold and sticky timeout.
module wdt_multi_win #(
    parameter int unsigned      NUM_CH      = 4,
    parameter int unsigned      CNT_W       = 32,
    parameter int unsigned      PRE_W       = 8,
    parameter int unsigned      DEF_TIMEOUT = 1000,
    parameter logic [CNT_W-1:0] DEF_WINDOW  = '1,
    parameter int unsigned      DEF_WARN    = 0,
    localparam int unsigned     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PRE_W-1:0]  pre_div,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_sel,
    input  logic [CNT_W-1:0]  cfg_data,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] kick,
    input  logic [NUM_CH-1:0] wto_clr,
    output logic [NUM_CH-1:0] wto,
    output logic [NUM_CH-1:0] early,
    output logic [NUM_CH-1:0] warn,
    output logic              any_wto
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        EXPIRED
    } state_e;

    logic [PRE_W-1:0]  pcnt_q, pcnt_d;
    logic              tick;

    logic [CNT_W-1:0]  tmo_q [NUM_CH];
    logic [CNT_W-1:0]  win_q [NUM_CH];
    logic [CNT_W-1:0]  wrn_q [NUM_CH];

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];

    logic [NUM_CH-1:0] wto_q, wto_d;
    logic [NUM_CH-1:0] early_q, early_d;
    logic [NUM_CH-1:0] warn_q, warn_d;
    logic              any_q, any_d;

    // A shrinking pre_div below the running count forces a wrap to 0.
    always_comb begin
        tick   = (pcnt_q == pre_div);
        pcnt_d = (pcnt_q >= pre_div) ? '0 : pcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tmo_q[i] <= CNT_W'(DEF_TIMEOUT);
                win_q[i] <= DEF_WINDOW;
                wrn_q[i] <= CNT_W'(DEF_WARN);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    case (cfg_sel)
                        2'd0:    tmo_q[i] <= cfg_data;
                        2'd1:    win_q[i] <= cfg_data;
                        2'd2:    wrn_q[i] <= cfg_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            wto_d[i]   = wto_q[i];
            early_d[i] = early_q[i];

            unique case (state_q[i])
                IDLE: begin
                    if (wto_clr[i]) begin
                        wto_d[i]   = 1'b0;
                        early_d[i] = 1'b0;
                    end
                    if (en[i]) begin
                        state_d[i] = COUNT;
                        cnt_d[i]   = tmo_q[i];
                    end
                end
                COUNT: begin
                    if (wto_clr[i]) begin
                        wto_d[i]   = 1'b0;
                        early_d[i] = 1'b0;
                    end
                    if (!en[i]) begin
                        state_d[i] = IDLE;
                    end else if (kick[i]) begin
                        if (cnt_q[i] > win_q[i]) begin
                            state_d[i] = EXPIRED;
                            wto_d[i]   = 1'b1;
                            early_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = tmo_q[i];
                        end
                    end else if (tick) begin
                        if (cnt_q[i] == '0) begin
                            state_d[i] = EXPIRED;
                            wto_d[i]   = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] - 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    if (wto_clr[i]) begin
                        wto_d[i]   = 1'b0;
                        early_d[i] = 1'b0;
                        if (en[i]) begin
                            state_d[i] = COUNT;
                            cnt_d[i]   = tmo_q[i];
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end else if (!en[i]) begin
                        state_d[i] = IDLE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase

            warn_d[i] = (state_d[i] == COUNT) && (cnt_d[i] <= wrn_q[i]);
        end
    end

    assign any_d = |wto_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            wto_q   <= '0;
            early_q <= '0;
            warn_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            wto_q   <= wto_d;
            early_q <= early_d;
            warn_q  <= warn_d;
            any_q   <= any_d;
        end
    end

    assign wto     = wto_q;
    assign early   = early_q;
    assign warn    = warn_q;
    assign any_wto = any_q;

endmodule
